// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and helpers: standard mode geometries,
// polarity encodings and region-boundary arithmetic.
package vga_timing_pkg;

    localparam bit POL_NEG = 1'b0;
    localparam bit POL_POS = 1'b1;

    // 640x480@60, 25.175 MHz pixel clock, 800x525 totals
    localparam int VGA640_H_ACTIVE = 640;
    localparam int VGA640_H_FP     = 16;
    localparam int VGA640_H_SYNC   = 96;
    localparam int VGA640_H_BP     = 48;
    localparam int VGA640_V_ACTIVE = 480;
    localparam int VGA640_V_FP     = 10;
    localparam int VGA640_V_SYNC   = 2;
    localparam int VGA640_V_BP     = 33;
    localparam bit VGA640_SYNC_POL = POL_NEG;

    // 800x600@60, 40 MHz pixel clock, 1056x628 totals
    localparam int SVGA800_H_ACTIVE = 800;
    localparam int SVGA800_H_FP     = 40;
    localparam int SVGA800_H_SYNC   = 128;
    localparam int SVGA800_H_BP     = 88;
    localparam int SVGA800_V_ACTIVE = 600;
    localparam int SVGA800_V_FP     = 1;
    localparam int SVGA800_V_SYNC   = 4;
    localparam int SVGA800_V_BP     = 23;
    localparam bit SVGA800_SYNC_POL = POL_POS;

    function automatic int calc_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int sync_start(input int active, input int fp);
        return active + fp;
    endfunction

    // Last position (inclusive) of the sync pulse.
    function automatic int sync_end(input int active, input int fp, input int sync);
        return active + fp + sync - 1;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Wrap-around position counter for one raster axis, with a registered
// terminal-count flag and the look-ahead value used by the output registers.
module vga_axis_counter #(
    parameter int CNT_W   = 10,
    parameter int TOTAL   = 800,
    parameter int RST_VAL = TOTAL - 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_adv,
    output logic [CNT_W-1:0] o_cnt,
    output logic [CNT_W-1:0] o_cnt_next,
    output logic             o_tc
);

    localparam logic [CNT_W-1:0] LAST   = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] CNT_RV = CNT_W'(RST_VAL);
    localparam logic             TC_RV  = (RST_VAL == TOTAL - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_adv) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
        tc_d = (cnt_d == LAST);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= CNT_RV;
            tc_q  <= TC_RV;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
        end
    end

    assign o_cnt      = cnt_q;
    assign o_cnt_next = cnt_d;
    assign o_tc       = tc_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: column/row counters with
// registered syncs, data-enable, frame strobes and a completed-frame counter.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE   = VGA640_H_ACTIVE,
    parameter int H_FP       = VGA640_H_FP,
    parameter int H_SYNC     = VGA640_H_SYNC,
    parameter int H_BP       = VGA640_H_BP,
    parameter int V_ACTIVE   = VGA640_V_ACTIVE,
    parameter int V_FP       = VGA640_V_FP,
    parameter int V_SYNC     = VGA640_V_SYNC,
    parameter int V_BP       = VGA640_V_BP,
    parameter bit H_SYNC_POL = VGA640_SYNC_POL,
    parameter bit V_SYNC_POL = VGA640_SYNC_POL,
    parameter int CNT_W      = 10,
    parameter int FRAME_W    = 8
) (
    input  logic               i_Clk,
    input  logic               i_Rst_n,
    input  logic               i_Enable,
    output logic               o_HSync,
    output logic               o_VSync,
    output logic               o_Active,
    output logic               o_SOF,
    output logic               o_EOL,
    output logic               o_EOF,
    output logic [CNT_W-1:0]   o_Col_Count,
    output logic [CNT_W-1:0]   o_Row_Count,
    output logic [FRAME_W-1:0] o_Frame_Count
);

    localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int MAX_TOTAL = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;

    localparam logic [CNT_W-1:0] H_SS    = CNT_W'(sync_start(H_ACTIVE, H_FP));
    localparam logic [CNT_W-1:0] H_SE    = CNT_W'(sync_end(H_ACTIVE, H_FP, H_SYNC));
    localparam logic [CNT_W-1:0] V_SS    = CNT_W'(sync_start(V_ACTIVE, V_FP));
    localparam logic [CNT_W-1:0] V_SE    = CNT_W'(sync_end(V_ACTIVE, V_FP, V_SYNC));
    localparam logic [CNT_W-1:0] H_ACT_C = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_ACTIVE - 1);

    if ((64'd1 << CNT_W) < 64'(MAX_TOTAL)) begin : g_cnt_w_too_small
        $fatal(1, "vga_timing_gen: CNT_W too narrow for raster totals");
    end
    if (H_SYNC < 1 || V_SYNC < 1) begin : g_zero_sync
        $fatal(1, "vga_timing_gen: sync width must be at least 1");
    end

    logic [CNT_W-1:0] col_q, col_d, row_q, row_d;
    logic             h_tc, v_tc, v_adv, wrap;

    // The row advances on the same edge that the column wraps.
    assign v_adv = i_Enable & h_tc;
    assign wrap  = i_Enable & h_tc & v_tc;

    vga_axis_counter #(.CNT_W(CNT_W), .TOTAL(H_TOTAL), .RST_VAL(H_TOTAL - 1)) u_h_cnt (
        .i_clk      (i_Clk),
        .i_rst_n    (i_Rst_n),
        .i_adv      (i_Enable),
        .o_cnt      (col_q),
        .o_cnt_next (col_d),
        .o_tc       (h_tc)
    );

    vga_axis_counter #(.CNT_W(CNT_W), .TOTAL(V_TOTAL), .RST_VAL(V_TOTAL - 1)) u_v_cnt (
        .i_clk      (i_Clk),
        .i_rst_n    (i_Rst_n),
        .i_adv      (v_adv),
        .o_cnt      (row_q),
        .o_cnt_next (row_d),
        .o_tc       (v_tc)
    );

    logic               hsync_q, hsync_d, vsync_q, vsync_d, active_q, active_d;
    logic               sof_q, sof_d, eol_q, eol_d, eof_q, eof_d;
    logic               first_q, first_d;
    logic [FRAME_W-1:0] frame_q, frame_d;

    // Decode from the look-ahead position so every output lines up with the counters.
    always_comb begin
        hsync_d  = ((col_d >= H_SS) && (col_d <= H_SE)) ? H_SYNC_POL : ~H_SYNC_POL;
        vsync_d  = ((row_d >= V_SS) && (row_d <= V_SE)) ? V_SYNC_POL : ~V_SYNC_POL;
        active_d = (col_d < H_ACT_C) && (row_d < V_ACT_C);
        sof_d    = i_Enable && (col_d == '0) && (row_d == '0);
        eol_d    = i_Enable && (col_d == H_LAST) && (row_d < V_ACT_C);
        eof_d    = eol_d && (row_d == V_LAST);
        first_d  = first_q & ~wrap;
        frame_d  = frame_q + FRAME_W'(wrap & ~first_q);
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            hsync_q  <= ~H_SYNC_POL;
            vsync_q  <= ~V_SYNC_POL;
            active_q <= 1'b0;
            sof_q    <= 1'b0;
            eol_q    <= 1'b0;
            eof_q    <= 1'b0;
            first_q  <= 1'b1;
            frame_q  <= '0;
        end else begin
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            active_q <= active_d;
            sof_q    <= sof_d;
            eol_q    <= eol_d;
            eof_q    <= eof_d;
            first_q  <= first_d;
            frame_q  <= frame_d;
        end
    end

    assign o_HSync       = hsync_q;
    assign o_VSync       = vsync_q;
    assign o_Active      = active_q;
    assign o_SOF         = sof_q;
    assign o_EOL         = eol_q;
    assign o_EOF         = eof_q;
    assign o_Col_Count   = col_q;
    assign o_Row_Count   = row_q;
    assign o_Frame_Count = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 instance for reset/line timing, and a tiny
// 8x6 raster instance for frame, stall, frame-wrap and mid-frame reset behaviour.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic       rst1_n, en1;
    logic       hs1, vs1, act1, sof1, eol1, eof1;
    logic [9:0] col1, row1;
    logic [7:0] fr1;

    vga_timing_gen u_dut (
        .i_Clk         (clk),
        .i_Rst_n       (rst1_n),
        .i_Enable      (en1),
        .o_HSync       (hs1),
        .o_VSync       (vs1),
        .o_Active      (act1),
        .o_SOF         (sof1),
        .o_EOL         (eol1),
        .o_EOF         (eof1),
        .o_Col_Count   (col1),
        .o_Row_Count   (row1),
        .o_Frame_Count (fr1)
    );

    // Small raster: H 4/1/2/1 (total 8), V 3/1/1/1 (total 6), positive syncs
    logic       rst2_n, en2;
    logic       hs2, vs2, act2, sof2, eol2, eof2;
    logic [2:0] col2, row2;
    logic [1:0] fr2;

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1),
        .CNT_W(3), .FRAME_W(2)
    ) u_small (
        .i_Clk         (clk),
        .i_Rst_n       (rst2_n),
        .i_Enable      (en2),
        .o_HSync       (hs2),
        .o_VSync       (vs2),
        .o_Active      (act2),
        .o_SOF         (sof2),
        .o_EOL         (eol2),
        .o_EOF         (eof2),
        .o_Col_Count   (col2),
        .o_Row_Count   (row2),
        .o_Frame_Count (fr2)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Expected state of the small instance
    int ec, er, ef;
    bit efirst;
    int step_idx;

    task automatic small_reset_model();
        ec = 7; er = 5; ef = 0; efirst = 1'b1;
    endtask

    task automatic small_check(input bit en);
        bit eol_e;
        eol_e = en && ec == 3 && er < 3;
        check("s_col",   32'(col2), 32'(ec));
        check("s_row",   32'(row2), 32'(er));
        check("s_frame", 32'(fr2),  32'(ef));
        check("s_hsync", 32'(hs2),  32'(ec == 5 || ec == 6));
        check("s_vsync", 32'(vs2),  32'(er == 4));
        check("s_active",32'(act2), 32'(ec < 4 && er < 3));
        check("s_sof",   32'(sof2), 32'(en && ec == 0 && er == 0));
        check("s_eol",   32'(eol2), 32'(eol_e));
        check("s_eof",   32'(eof2), 32'(eol_e && er == 2));
    endtask

    task automatic small_step(input bit en);
        en2 = en;
        @(negedge clk);
        step_idx++;
        if (en) begin
            if (ec == 7) begin
                ec = 0;
                if (er == 5) begin
                    er = 0;
                    if (!efirst) ef = (ef + 1) % 4;
                    efirst = 1'b0;
                end else begin
                    er++;
                end
            end else begin
                ec++;
            end
        end
        small_check(en);
    endtask

    initial begin
        int act_cnt, eol_cnt, eol_col, hs_low, hs_first, hs_last, vs_low, sof_cnt, eof_cnt;
        int sof_at[$];
        int prev_fr;
        bit reached;

        rst1_n = 1'b1; en1 = 1'b1;
        rst2_n = 1'b1; en2 = 1'b0;
        step_idx = 0;
        #1;
        rst1_n = 1'b0;
        rst2_n = 1'b0;
        small_reset_model();

        // ---- Reset state, default instance
        repeat (5) @(negedge clk);
        check("rst_col",    32'(col1), 32'd799);
        check("rst_row",    32'(row1), 32'd524);
        check("rst_hsync",  32'(hs1),  32'd1);
        check("rst_vsync",  32'(vs1),  32'd1);
        check("rst_active", 32'(act1), 32'd0);
        check("rst_sof",    32'(sof1), 32'd0);
        check("rst_eol",    32'(eol1), 32'd0);
        check("rst_eof",    32'(eof1), 32'd0);
        check("rst_frame",  32'(fr1),  32'd0);
        $display("reset: col=%0d row=%0d hs=%0d vs=%0d", col1, row1, hs1, vs1);

        rst1_n = 1'b1;
        @(negedge clk);
        check("first_col",    32'(col1), 32'd0);
        check("first_row",    32'(row1), 32'd0);
        check("first_active", 32'(act1), 32'd1);
        check("first_sof",    32'(sof1), 32'd1);
        check("first_frame",  32'(fr1),  32'd0);
        $display("release: col=%0d row=%0d sof=%0d", col1, row1, sof1);

        // ---- One full line
        act_cnt = 0; eol_cnt = 0; eol_col = -1; hs_low = 0; hs_first = -1; hs_last = -1;
        vs_low = 0; sof_cnt = 0; eof_cnt = 0;
        for (int i = 0; i < 800; i++) begin
            if (act1) act_cnt++;
            if (eol1) begin eol_cnt++; eol_col = int'(col1); end
            if (!hs1) begin
                hs_low++;
                if (hs_first < 0) hs_first = int'(col1);
                hs_last = int'(col1);
            end
            if (!vs1) vs_low++;
            if (sof1) sof_cnt++;
            if (eof1) eof_cnt++;
            @(negedge clk);
        end
        check("line_active_cnt", 32'(act_cnt),  32'd640);
        check("line_eol_cnt",    32'(eol_cnt),  32'd1);
        check("line_eol_col",    32'(eol_col),  32'd639);
        check("line_hs_low",     32'(hs_low),   32'd96);
        check("line_hs_first",   32'(hs_first), 32'd656);
        check("line_hs_last",    32'(hs_last),  32'd751);
        check("line_vs_low",     32'(vs_low),   32'd0);
        check("line_sof_cnt",    32'(sof_cnt),  32'd1);
        check("line_eof_cnt",    32'(eof_cnt),  32'd0);
        check("line_wrap_col",   32'(col1),     32'd0);
        check("line_wrap_row",   32'(row1),     32'd1);
        $display("line: active=%0d eol@%0d hs_low=%0d (%0d..%0d)", act_cnt, eol_col, hs_low, hs_first, hs_last);

        // ---- Mid-line asynchronous reset, default instance
        repeat (300) @(negedge clk);
        check("mid_col_pre", 32'(col1), 32'd300);
        check("mid_act_pre", 32'(act1), 32'd1);
        #2 rst1_n = 1'b0;
        #1;
        check("mid_rst_col",    32'(col1), 32'd799);
        check("mid_rst_row",    32'(row1), 32'd524);
        check("mid_rst_active", 32'(act1), 32'd0);
        check("mid_rst_hsync",  32'(hs1),  32'd1);
        repeat (2) @(negedge clk);
        rst1_n = 1'b1;
        @(negedge clk);
        check("mid_rel_col", 32'(col1), 32'd0);
        check("mid_rel_row", 32'(row1), 32'd0);
        check("mid_rel_sof", 32'(sof1), 32'd1);
        en1 = 1'b0;
        @(negedge clk);
        check("stall_col", 32'(col1), 32'd0);
        check("stall_sof", 32'(sof1), 32'd0);
        check("stall_act", 32'(act1), 32'd1);
        $display("mid-line reset and stall: col=%0d sof=%0d", col1, sof1);

        // ---- Small instance: reset state and release
        check("s_rst_col",   32'(col2), 32'd7);
        check("s_rst_row",   32'(row2), 32'd5);
        check("s_rst_hsync", 32'(hs2),  32'd0);
        check("s_rst_vsync", 32'(vs2),  32'd0);
        rst2_n = 1'b1;
        small_step(1'b1);
        $display("small release: col=%0d row=%0d sof=%0d", col2, row2, sof2);

        // ---- Five free-running frames; frame counter wraps 3 -> 0
        prev_fr = int'(fr2);
        for (int i = 0; i < 5 * 48; i++) begin
            small_step(1'b1);
            if (sof2) begin
                $display("small frame boundary: frame=%0d", fr2);
                if (prev_fr == 3) check("s_frame_wrap", 32'(fr2), 32'd0);
                prev_fr = int'(fr2);
            end
        end

        // ---- Enable toggled every cycle: frame period doubles to 96
        for (int i = 0; i < 200; i++) begin
            small_step(i[0]);
            if (sof2) sof_at.push_back(step_idx);
        end
        check("s_toggle_sofs", 32'(sof_at.size()), 32'd2);
        if (sof_at.size() >= 2) begin
            check("s_toggle_period", 32'(sof_at[1] - sof_at[0]), 32'd96);
            $display("toggle: sof period=%0d", sof_at[1] - sof_at[0]);
        end

        // ---- Asynchronous reset at (2,1) with a nonzero frame count
        reached = 1'b0;
        for (int i = 0; i < 100 && !reached; i++) begin
            small_step(1'b1);
            if (ec == 2 && er == 1) reached = 1'b1;
        end
        check("s_reach_pos", 32'(reached), 32'd1);
        check("s_frame_pre_rst", 32'(fr2), 32'd3);
        #2 rst2_n = 1'b0;
        #1;
        small_reset_model();
        check("s_mid_rst_col",   32'(col2), 32'd7);
        check("s_mid_rst_row",   32'(row2), 32'd5);
        check("s_mid_rst_frame", 32'(fr2),  32'd0);
        check("s_mid_rst_act",   32'(act2), 32'd0);
        en2 = 1'b0;
        @(negedge clk);
        rst2_n = 1'b1;
        small_step(1'b1);
        check("s_mid_rel_sof", 32'(sof2), 32'd1);
        for (int i = 0; i < 60; i++) small_step(1'b1);
        $display("small mid-frame reset: frame after one wrap=%0d", fr2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator: successor of the fixed 800x525 sync generator.
- Explicit front-porch, sync and back-porch widths per axis.
- Programmable sync polarity and pixel clock-enable.
- Registered data-enable, start-of-frame, end-of-line and end-of-frame strobes, plus a frame counter.
- Sits between the pixel clock domain and the pattern/sprite renderers and the VGA output stage.

Parameters:
H_ACTIVE, 640, visible columns
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible rows
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
H_SYNC_POL, 0, asserted level of o_HSync (0 = active-low)
V_SYNC_POL, 0, asserted level of o_VSync
CNT_W, 10, width of o_Col_Count/o_Row_Count
FRAME_W, 8, width of o_Frame_Count

Ports:
i_Clk  in  1  pixel clock
i_Rst_n  in  1  asynchronous active-low reset
i_Enable  in  1  pixel advance enable; low freezes all state
o_HSync  out  1  horizontal sync, level per H_SYNC_POL
o_VSync  out  1  vertical sync, level per V_SYNC_POL
o_Active  out  1  data enable: current position is visible
o_SOF  out  1  one-cycle strobe at position (0,0)
o_EOL  out  1  one-cycle strobe at last visible pixel of a visible line
o_EOF  out  1  one-cycle strobe at (H_ACTIVE-1, V_ACTIVE-1)
o_Col_Count  out  CNT_W  current column
o_Row_Count  out  CNT_W  current row
o_Frame_Count  out  FRAME_W  completed-frame counter, modulo 2^FRAME_W

Behaviour:
- Derived values: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525 by default).
- Elaboration-time check: 2^CNT_W must be at least max(H_TOTAL, V_TOTAL). Failure is a fatal error.
- All outputs are registered. On every cycle, all outputs describe the position held in o_Col_Count/o_Row_Count, with zero skew between them.
- Reset (i_Rst_n low, asynchronous) puts the block at position (H_TOTAL-1, V_TOTAL-1):
  - o_Col_Count = H_TOTAL-1, o_Row_Count = V_TOTAL-1, o_Frame_Count = 0.
  - o_HSync = ~H_SYNC_POL, o_VSync = ~V_SYNC_POL.
  - o_Active = 0, o_SOF = 0, o_EOL = 0, o_EOF = 0.
- Reset release: the first clock edge with i_Enable=1 wraps to (0,0), asserts o_SOF and o_Active, and leaves o_Frame_Count at 0.
- Advance (i_Enable=1):
  - Column increments by 1.
  - At H_TOTAL-1 the column wraps to 0 and the row increments.
  - At row V_TOTAL-1 the row wraps to 0.
- Frame counter: increments on each wrap into (0,0) except the first one after reset, and wraps modulo 2^FRAME_W.
- Stall (i_Enable=0): counters, syncs, o_Active and o_Frame_Count hold their values. o_SOF/o_EOL/o_EOF drop to 0 on that edge, so each strobe is high for exactly one enabled cycle. On the next enabled advance the strobes reflect the new position.
- o_HSync asserted iff H_ACTIVE+H_FP <= col <= H_ACTIVE+H_FP+H_SYNC-1 (656..751 default), independent of row.
- o_VSync asserted iff V_ACTIVE+V_FP <= row <= V_ACTIVE+V_FP+V_SYNC-1 (490..491 default). It changes only together with a row change, i.e. at col 0.
- o_Active = (col < H_ACTIVE) and (row < V_ACTIVE).
- o_EOL = (col == H_ACTIVE-1) and (row < V_ACTIVE).
- o_EOF = o_EOL and (row == V_ACTIVE-1).
- Reset asserted mid-frame: immediate return to the reset values above. There are no partial strobes after release.
- Zero-width porches (H_FP=0, etc.) are legal; the region boundaries follow the formulas unchanged. Zero-width sync is illegal and is an elaboration error.

Decomposition:
- Shared package vga_timing_pkg:
  - Mode constants for 640x480@60 (800/525) and 800x600@60 (1056/628 totals, positive polarity).
  - Total/sync-start/sync-end computation functions.
  - Polarity localparams.
- One natural sub-module, vga_axis_counter: a wrap counter parametrised by TOTAL and reset value, with an advance input and a registered terminal-count output. It is instantiated twice; the horizontal terminal count, ANDed with i_Enable, advances the vertical instance.

Test Plan:
1. Reset held 5 cycles, i_Enable=1 -> Col=799, Row=524, HSync=VSync=1, Active/SOF=0. First enabled edge after release -> Col=0, Row=0, Active=1, SOF=1, Frame=0.
2. Free-run one full line, default params -> Active high for cols 0..639, EOL only at col 639, HSync low exactly for cols 656..751 (96 cycles), line period 800 cycles.
3. Free-run one full frame -> VSync low only on rows 490-491 (1600 cycles), EOF once at (639,479), next SOF 420000 cycles after the previous one, Frame=1.
4. i_Enable toggled 1/0 every cycle -> counters advance every other cycle, each strobe high exactly 1 cycle, frame period 840000 cycles.
5. Reset pulsed at (300,200) -> outputs return to reset values asynchronously; frame count 0; next SOF on the first enabled edge after release.
6. Small params: H 4/1/2/1, V 3/1/1/1, polarities 1, FRAME_W=2 -> HSync high at col 5..6, VSync high at row 4, Frame wraps 3->0 after 4 completed frames.
